// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualification and synchronous system reset sequencer
module pll_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             locked,
  output logic             rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_count
);

  localparam int STABLE_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  locked_s;
  logic [STABLE_W-1:0]   stable_q, stable_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]      loss_q, loss_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= WAIT_LOCK;
      stable_q <= '0;
      hold_q   <= '0;
      loss_q   <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], locked};
      state_q  <= state_d;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      loss_q   <= loss_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    hold_d   = hold_q;
    loss_d   = loss_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!locked_s) begin
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d = HOLD;
          hold_d  = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      HOLD: begin
        // Losing lock before release is not counted as a loss event
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
          if (loss_q != CNT_MAX) loss_d = loss_q + 1'b1;
        end
      end
      default: begin
        state_d  = WAIT_LOCK;
        stable_d = '0;
      end
    endcase
  end

  assign rst_out         = (state_q != RUN);
  assign ready           = (state_q == RUN);
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       rst_out;
  logic       ready;
  logic [1:0] lock_loss_count;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(2),
    .LOCK_CYCLES(4),
    .HOLD_CYCLES(3),
    .CNT_W(2)
  ) dut (
    .clock_in(clk),
    .reset(reset),
    .locked(locked),
    .rst_out(rst_out),
    .ready(ready),
    .lock_loss_count(lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Edge numbering restarts at 0 on the reset edge; inputs set now are sampled at edge 1
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edge_n = 0;
  endtask

  task automatic check_state(input string name, input logic exp_rst, input logic [1:0] exp_cnt);
    checks++;
    if (rst_out !== exp_rst || ready !== ~exp_rst) begin
      errors++;
      $display("FAIL %s edge=%0d: rst_out=%b ready=%b, required rst_out=%b ready=%b",
               name, edge_n, rst_out, ready, exp_rst, ~exp_rst);
    end
    checks++;
    if (lock_loss_count !== exp_cnt) begin
      errors++;
      $display("FAIL %s_count edge=%0d: lock_loss_count=%0d, required %0d",
               name, edge_n, lock_loss_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    locked = 1'b0;
    do_reset();
    check_state("reset_value", 1'b1, 2'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_state("locked_low_hold", 1'b1, 2'd0);
    end
  endtask

  task automatic test_lock();
    locked = 1'b0;
    do_reset();
    tick_to(9);
    locked = 1'b1;
    tick_to(17);
    check_state("lock_not_early", 1'b1, 2'd0);
    tick_to(18);
    check_state("lock_release", 1'b0, 2'd0);
  endtask

  task automatic test_glitch();
    locked = 1'b0;
    do_reset();
    tick_to(9);
    locked = 1'b1;
    tick_to(11);
    locked = 1'b0;
    tick_to(12);
    locked = 1'b1;
    tick_to(18);
    check_state("glitch_restart_18", 1'b1, 2'd0);
    tick_to(20);
    check_state("glitch_not_early", 1'b1, 2'd0);
    tick_to(21);
    check_state("glitch_release", 1'b0, 2'd0);
  endtask

  // Continues from the RUN state reached in test_glitch
  task automatic test_loss_relock();
    tick_to(39);
    locked = 1'b0;
    tick_to(41);
    check_state("loss_sync_delay", 1'b0, 2'd0);
    tick_to(42);
    check_state("loss_detect", 1'b1, 2'd1);
    tick_to(44);
    locked = 1'b1;
    tick_to(52);
    check_state("relock_not_early", 1'b1, 2'd1);
    tick_to(53);
    check_state("relock_release", 1'b0, 2'd1);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    exp_cnt = 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      locked = 1'b0;
      tick();
      locked = 1'b1;
      tick();
      tick();
      check_state("sat_loss", 1'b1, exp_cnt);
      for (int j = 0; j < 6; j++) tick();
      check_state("sat_not_early", 1'b1, exp_cnt);
      tick();
      check_state("sat_relock", 1'b0, exp_cnt);
    end
    reset = 1'b1;
    tick();
    check_state("count_cleared", 1'b1, 2'd0);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    locked = 1'b1;
    do_reset();
    tick_to(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_state("reset_in_hold", 1'b1, 2'd0);
    edge_n = 0;
    tick_to(8);
    check_state("hold_reset_not_early", 1'b1, 2'd0);
    tick_to(9);
    check_state("hold_reset_rerun", 1'b0, 2'd0);
    tick_to(12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_state("reset_in_run", 1'b1, 2'd0);
    edge_n = 0;
    tick_to(8);
    check_state("run_reset_not_early", 1'b1, 2'd0);
    tick_to(9);
    check_state("run_reset_rerun", 1'b0, 2'd0);
  endtask

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_glitch();
    test_loss_relock();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
